sram_pattern_tester: RTL and testbench

Self-checking built-in tester for an external asynchronous SRAM. It sweeps a fixed sequence of data patterns across the whole address space: it writes every address, then reads every address back and compares each word. It raises a sticky pass/fail flag and pulses a done strobe after each full sweep, then loops forever. It sits between the FPGA fabric and the SRAM I/O pins; the bench connects it to a behavioural SRAM (`sram_model`).

---
 rtl/sram_pattern_tester_if.sv | 36 +++
 rtl/sram_pattern_tester.sv | 195 +++++++++++++++++++
 tb/tb_sram_pattern_tester.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_pattern_tester_if.sv
// Status, request-mirror and SRAM control pins of the SRAM pattern tester.
// The bidirectional data pins stay a plain inout port on the tester itself.
// master: driven by the tester. slave: observers (fabric logic, SRAM pin model).
interface sram_pattern_tester_if #(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 16
);
  // status towards the fabric
  logic                 test_done;           // one-cycle strobe per full sweep
  logic                 test_pass;           // sticky, cleared by first mismatch
  logic [2:0]           pattern_state;       // active pattern index 0..5
  logic [DATA_BITS-1:0] prev_expected_data;  // expected word of last compare
  logic [DATA_BITS-1:0] prev_read_data;      // read word of last compare
  // internal request mirror
  logic                 write_enable;
  logic [ADDR_BITS-1:0] addr;
  logic [DATA_BITS-1:0] write_data;
  logic [DATA_BITS-1:0] read_data;
  // SRAM control pins (active low)
  logic [ADDR_BITS-1:0] addr_bus;
  logic                 we_n;
  logic                 oe_n;
  logic                 ce_n;

  modport master (
    output test_done, test_pass, pattern_state, prev_expected_data, prev_read_data,
    output write_enable, addr, write_data, read_data,
    output addr_bus, we_n, oe_n, ce_n
  );

  modport slave (
    input test_done, test_pass, pattern_state, prev_expected_data, prev_read_data,
    input write_enable, addr, write_data, read_data,
    input addr_bus, we_n, oe_n, ce_n
  );
endinterface

// File: rtl/sram_pattern_tester.sv
// Purpose: built-in tester for an asynchronous SRAM; writes then verifies six
//   data patterns over the whole address space, forever, with a sticky pass flag.
// Latency: 2 clocks per write, 2 clocks per read; one sweep = 24 * 2^ADDR_BITS + 1 clocks.
// Backpressure: none; the SRAM is assumed to settle within one read cycle.
// Ports:
//   clk        system clock
//   reset      synchronous, active low
//   tst        status / request mirror / SRAM control pins (master modport)
//   data_bus   SRAM data pins; driven only while writing, high-Z otherwise
module sram_pattern_tester #(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  sram_pattern_tester_if.master tst,
  inout  wire  [DATA_BITS-1:0] data_bus
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_WRITE1 = 3'd1,
    ST_WRITE2 = 3'd2,
    ST_READ1  = 3'd3,
    ST_READ2  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [ADDR_BITS-1:0] LAST_ADDR    = '1;
  localparam logic [2:0]           LAST_PATTERN = 3'd5;

  // 0101... with LSB set, built wide then trimmed so any DATA_BITS works
  localparam logic [2*DATA_BITS-1:0] ALT_WIDE = {DATA_BITS{2'b01}};
  localparam logic [DATA_BITS-1:0]   PAT_0101 = ALT_WIDE[DATA_BITS-1:0];
  localparam logic [DATA_BITS-1:0]   PAT_1010 = ~PAT_0101;

  // bits of the address that fit in a data word (zero-extend or truncate)
  localparam int COPY_BITS = (ADDR_BITS < DATA_BITS) ? ADDR_BITS : DATA_BITS;

  function automatic logic [DATA_BITS-1:0] pattern_word(
    input logic [2:0]           pat,
    input logic [ADDR_BITS-1:0] a
  );
    logic [DATA_BITS-1:0] w;
    w = '0;
    case (pat)
      3'd0: w = '0;
      3'd1: w = '1;
      3'd2: w = PAT_0101;
      3'd3: w = PAT_1010;
      3'd4: w = a[0] ? PAT_1010 : PAT_0101;
      3'd5: w[COPY_BITS-1:0] = a[COPY_BITS-1:0];
      default: w = '0;
    endcase
    return w;
  endfunction

  state_t               state;
  logic [2:0]           pat_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] wdata_q;
  logic                 drive_q;
  logic                 wr_en_q;
  logic                 we_n_q;
  logic                 oe_n_q;
  logic                 ce_n_q;
  logic                 done_q;
  logic                 pass_q;
  logic [DATA_BITS-1:0] prev_exp_q;
  logic [DATA_BITS-1:0] prev_rd_q;
  logic [DATA_BITS-1:0] rdata_q;

  // Every output is a register; each transition loads the pin values of the
  // state being entered, so the pins always match the current state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_RESET;
      pat_q      <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      drive_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      we_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      ce_n_q     <= 1'b1;
      done_q     <= 1'b0;
      pass_q     <= 1'b1;
      prev_exp_q <= '0;
      prev_rd_q  <= '0;
      rdata_q    <= '0;
    end else begin
      ce_n_q <= 1'b0;
      done_q <= 1'b0;
      case (state)
        ST_RESET, ST_DONE: begin
          // start (or restart) the sweep: pattern 0, address 0, write
          state   <= ST_WRITE1;
          pat_q   <= 3'd0;
          addr_q  <= '0;
          wdata_q <= pattern_word(3'd0, '0);
          drive_q <= 1'b1;
          wr_en_q <= 1'b1;
          we_n_q  <= 1'b0;
          oe_n_q  <= 1'b1;
        end

        ST_WRITE1: begin
          // address and data stay put; the SRAM latches on this we_n rise
          state  <= ST_WRITE2;
          we_n_q <= 1'b1;
        end

        ST_WRITE2: begin
          if (addr_q == LAST_ADDR) begin
            // release the bus one full cycle before oe_n is asserted? No:
            // drive_q and oe_n change on the same edge, and the bus is never
            // driven while oe_n is low because both come from registers.
            state   <= ST_READ1;
            addr_q  <= '0;
            wdata_q <= pattern_word(pat_q, '0);
            drive_q <= 1'b0;
            wr_en_q <= 1'b0;
            oe_n_q  <= 1'b0;
          end else begin
            state   <= ST_WRITE1;
            addr_q  <= addr_q + 1'b1;
            wdata_q <= pattern_word(pat_q, addr_q + 1'b1);
            we_n_q  <= 1'b0;
          end
        end

        ST_READ1: begin
          // give the asynchronous SRAM a full extra cycle to settle
          state <= ST_READ2;
        end

        ST_READ2: begin
          // wdata_q always holds pattern(addr), so it is the expected word
          rdata_q    <= data_bus;
          prev_rd_q  <= data_bus;
          prev_exp_q <= wdata_q;
          if (data_bus != wdata_q) begin
            pass_q <= 1'b0;
          end

          if (addr_q != LAST_ADDR) begin
            state   <= ST_READ1;
            addr_q  <= addr_q + 1'b1;
            wdata_q <= pattern_word(pat_q, addr_q + 1'b1);
          end else if (pat_q == LAST_PATTERN) begin
            state   <= ST_DONE;
            addr_q  <= '0;
            wdata_q <= pattern_word(pat_q, '0);
            oe_n_q  <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            state   <= ST_WRITE1;
            pat_q   <= pat_q + 3'd1;
            addr_q  <= '0;
            wdata_q <= pattern_word(pat_q + 3'd1, '0);
            drive_q <= 1'b1;
            wr_en_q <= 1'b1;
            we_n_q  <= 1'b0;
            oe_n_q  <= 1'b1;
          end
        end

        default: begin
          state   <= ST_RESET;
          drive_q <= 1'b0;
          wr_en_q <= 1'b0;
          we_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
        end
      endcase
    end
  end

  assign data_bus = drive_q ? wdata_q : {DATA_BITS{1'bz}};

  assign tst.test_done          = done_q;
  assign tst.test_pass          = pass_q;
  assign tst.pattern_state      = pat_q;
  assign tst.prev_expected_data = prev_exp_q;
  assign tst.prev_read_data     = prev_rd_q;
  assign tst.write_enable       = wr_en_q;
  assign tst.addr               = addr_q;
  assign tst.write_data         = wdata_q;
  assign tst.read_data          = rdata_q;
  assign tst.addr_bus           = addr_q;
  assign tst.we_n               = we_n_q;
  assign tst.oe_n               = oe_n_q;
  assign tst.ce_n               = ce_n_q;

endmodule

// File: tb/tb_sram_pattern_tester.sv
// Bench for sram_pattern_tester with a behavioural async SRAM, a scoreboard of
// expected compare events / done strobes, and a pin-protocol monitor.
module tb_sram_pattern_tester;
  localparam int AB    = 4;
  localparam int DB    = 2;
  localparam int N     = 1 << AB;
  localparam int SWEEP = 6 * 4 * N + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  wire [DB-1:0] data_bus;

  sram_pattern_tester_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) tst ();

  sram_pattern_tester #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk      (clk),
    .reset    (reset),
    .tst      (tst),
    .data_bus (data_bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural SRAM ----------------
  logic [DB-1:0] mem [N];
  logic          stuck0 = 1'b0;
  logic [DB-1:0] sram_out;

  always_comb sram_out = mem[tst.addr_bus] & {{(DB-1){1'b1}}, ~stuck0};
  assign data_bus = (!tst.ce_n && !tst.oe_n && tst.we_n) ? sram_out : {DB{1'bz}};
  always @(posedge tst.we_n) if (!tst.ce_n) mem[tst.addr_bus] <= data_bus;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  typedef struct {
    int pat;
    int a;
    int exp_w;
    int rd_w;
    bit pass;
  } ev_t;

  ev_t ev_q[$];
  int  done_q[$];

  logic rst_at_edge = 1'b1;
  int   cyc = 0;
  always @(posedge clk) begin
    rst_at_edge <= !reset;
    cyc <= reset ? cyc + 1 : 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event occurred, required none (cycle %0d)", name, cyc);
  endtask

  // Pattern words from their definitions, in plain integer arithmetic.
  function automatic int ref_pat(input int p, input int a);
    int ones;
    int alt;
    ones = (1 << DB) - 1;
    alt = 0;
    for (int i = 0; i < DB; i += 2) alt += (1 << i);
    case (p)
      0: return 0;
      1: return ones;
      2: return alt;
      3: return ones - alt;
      4: return (a % 2 == 0) ? alt : ones - alt;
      5: return a % (1 << DB);
      default: return 0;
    endcase
  endfunction

  task automatic push_sweeps(input int n, input bit fault);
    bit pass;
    pass = 1'b1;
    for (int s = 0; s < n; s++) begin
      for (int p = 0; p < 6; p++) begin
        for (int a = 0; a < N; a++) begin
          ev_t e;
          e.pat   = p;
          e.a     = a;
          e.exp_w = ref_pat(p, a);
          e.rd_w  = fault ? (e.exp_w & ~1) : e.exp_w;
          pass    = pass && (e.rd_w == e.exp_w);
          e.pass  = pass;
          ev_q.push_back(e);
        end
      end
      done_q.push_back((s + 1) * SWEEP);
    end
  endtask

  // ---------------- monitor ----------------
  int   low_run = 0;
  bit   pend = 1'b0;
  int   cap_pat = 0;
  int   cap_a = 0;
  bit   cur_pass = 1'b1;
  int   done_cnt = 0;
  int   fall_cyc = -1;

  always @(negedge clk) begin
    if (rst_at_edge) begin
      low_run  = 0;
      pend     = 1'b0;
      cur_pass = 1'b1;
      fall_cyc = -1;
    end else begin
      if (pend) begin
        if (ev_q.size() == 0) begin
          fail_event("unexpected_compare");
        end else begin
          ev_t e;
          e = ev_q.pop_front();
          chk("cmp_pattern", cap_pat, e.pat);
          chk("cmp_addr", cap_a, e.a);
          chk("prev_expected_data", tst.prev_expected_data, e.exp_w);
          chk("prev_read_data", tst.prev_read_data, e.rd_w);
          chk("read_data", tst.read_data, e.rd_w);
          cur_pass = e.pass;
          if (!stuck0 && e.pat == 5 && e.a == 7) begin
            chk("p5_a7_prev_read", tst.prev_read_data, 32'd3);
            chk("p5_a7_prev_expected", tst.prev_expected_data, 32'd3);
          end
        end
      end
      chk("test_pass", tst.test_pass, cur_pass);
      if (!tst.test_pass && fall_cyc < 0) fall_cyc = cyc;
      chk("ce_n_active", tst.ce_n, 0);
      chk("addr_mirror", tst.addr, tst.addr_bus);
      if (!tst.we_n) chk("oe_n_during_we", tst.oe_n, 1);
      if (!tst.test_done)
        chk("write_data_mirror", tst.write_data, ref_pat(tst.pattern_state, tst.addr_bus));
      if (tst.write_enable) begin
        chk("write_bus_word", data_bus, ref_pat(tst.pattern_state, tst.addr_bus));
        if (!stuck0 && tst.pattern_state == 5 && tst.addr_bus == 7 && !tst.we_n)
          chk("p5_a7_write_word", data_bus, 32'd3);
      end
      if (!tst.oe_n) chk("read_bus_from_sram", data_bus, sram_out);

      pend = 1'b0;
      if (!tst.oe_n) begin
        low_run++;
        if (low_run % 2 == 0) begin
          pend    = 1'b1;
          cap_pat = tst.pattern_state;
          cap_a   = tst.addr_bus;
        end
      end else begin
        low_run = 0;
      end

      if (tst.test_done) begin
        done_cnt++;
        if (done_q.size() == 0) fail_event("unexpected_done");
        else chk("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_reset_state(input string tag);
    chk({tag, "_test_pass"}, tst.test_pass, 1);
    chk({tag, "_test_done"}, tst.test_done, 0);
    chk({tag, "_pattern_state"}, tst.pattern_state, 0);
    chk({tag, "_addr"}, tst.addr, 0);
    chk({tag, "_addr_bus"}, tst.addr_bus, 0);
    chk({tag, "_prev_expected"}, tst.prev_expected_data, 0);
    chk({tag, "_prev_read"}, tst.prev_read_data, 0);
    chk({tag, "_read_data"}, tst.read_data, 0);
    chk({tag, "_write_enable"}, tst.write_enable, 0);
    chk({tag, "_we_n"}, tst.we_n, 1);
    chk({tag, "_oe_n"}, tst.oe_n, 1);
    chk({tag, "_ce_n"}, tst.ce_n, 1);
  endtask

  task automatic wait_done(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (done_cnt < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (done_cnt < n) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: done strobes %0d, required %0d", tag, done_cnt, n);
    end
  endtask

  initial begin
    int k;
    int extra;
    for (int i = 0; i < N; i++) mem[i] <= DB'($urandom);

    // Phase A: 1-cycle reset, clean SRAM, two full sweeps.
    push_sweeps(2, 1'b0);
    @(negedge clk);
    check_reset_state("reset");
    reset = 1'b1;
    wait_done(2, 2 * SWEEP + 50, "clean");
    chk("clean_all_compares_seen", ev_q.size(), 0);

    // Phase B: data bit 0 stuck at 0.
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    ev_q.delete();
    done_q.delete();
    done_cnt = 0;
    stuck0 = 1'b1;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
    push_sweeps(2, 1'b1);
    reset = 1'b1;
    wait_done(1, SWEEP + 50, "fault");
    chk("fault_first_fail_cycle", fall_cyc, 6 * N + 3);

    // Run into the pattern 3 read phase, then abort with reset.
    k = 0;
    while (k < SWEEP && !(tst.pattern_state == 3 && !tst.oe_n)) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= SWEEP) begin
      checks++;
      failures++;
      $display("FAIL p3_read_timeout: pattern %0d, required 3", tst.pattern_state);
    end
    extra = $urandom_range(0, 20);
    repeat (extra) @(posedge clk);
    #1;
    chk("pre_abort_pass_low", tst.test_pass, 0);
    chk("pre_abort_pattern", tst.pattern_state, 3);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("abort");
    repeat ($urandom_range(1, 3)) begin
      @(negedge clk);
      chk("abort_hold_we_n", tst.we_n, 1);
      chk("abort_hold_oe_n", tst.oe_n, 1);
    end

    // Phase C: clean restart after the abort.
    @(posedge clk); #1;
    ev_q.delete();
    done_q.delete();
    done_cnt = 0;
    stuck0 = 1'b0;
    push_sweeps(1, 1'b0);
    reset = 1'b1;
    wait_done(1, SWEEP + 50, "restart");
    chk("restart_all_compares_seen", ev_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
